// File: rtl/display_scan_mux_pkg.sv
// Shared definitions for the display scan multiplexer: blank code, scan
// states and the index/counter width helper.
package display_scan_mux_pkg;

   localparam logic [3:0] BLANK_CODE = 4'h0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } scan_state_e;

   // Bits needed to hold the values 0..n-1 (never less than one bit).
   function automatic int idx_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/display_scan_mux_if.sv
// Bus between the display scan multiplexer and whoever feeds it digit codes;
// the outputs go on to the BCD_7SEG decoder and the digit drivers.
interface display_scan_mux_if
   import display_scan_mux_pkg::*;
#(
   parameter int NUM_DIGITS = 4
);

   localparam int IDX_W = idx_width(NUM_DIGITS);

   // No ready: load is a single-cycle strobe that the mux always accepts, the
   // last strobe before a frame commit wins. enable is a level, not a strobe.
   logic                      enable;
   logic                      load;
   logic [4*NUM_DIGITS-1:0]   digits_in;
   logic [3:0]                code_out;
   logic [NUM_DIGITS-1:0]     dig_en_n;
   logic [IDX_W-1:0]          digit_idx;
   logic                      frame_start;

   modport master (
      output enable, load, digits_in,
      input  code_out, dig_en_n, digit_idx, frame_start
   );

   modport slave (
      input  enable, load, digits_in,
      output code_out, dig_en_n, digit_idx, frame_start
   );

endinterface

// File: rtl/display_scan_mux_scan_timer.sv
// Loadable down-counter shared by the blank and show intervals; tc is high
// while the count sits at zero.
module scan_timer #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         tc
);

   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/display_scan_mux.sv
// Time-multiplexed scan of an N-digit common-anode 7-segment display with a
// blanking gap before each digit and frame-coherent digit updates.
module display_scan_mux
   import display_scan_mux_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SHOW_CYCLES  = 50000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   display_scan_mux_if.slave  bus,
   output scan_state_e        state_dbg
);

   localparam int IDX_W   = idx_width(NUM_DIGITS);
   localparam int MAX_CYC = (SHOW_CYCLES > BLANK_CYCLES) ? SHOW_CYCLES : BLANK_CYCLES;
   localparam int CW      = idx_width(MAX_CYC);

   localparam logic [CW-1:0]    BLANK_LD = CW'(BLANK_CYCLES - 1);
   localparam logic [CW-1:0]    SHOW_LD  = CW'(SHOW_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   scan_state_e               state, state_n;
   logic [IDX_W-1:0]          idx, idx_n;
   logic                      tmr_load, tmr_tc;
   logic [CW-1:0]             tmr_val;
   logic                      commit;

   logic [4*NUM_DIGITS-1:0]   shadow, shadow_n;
   logic [4*NUM_DIGITS-1:0]   pending, pending_n;
   logic                      pv, pv_n;

   logic [3:0]                code_q, code_n, code_sel;
   logic [NUM_DIGITS-1:0]     dig_q, dig_n;
   logic                      fs_q;

   scan_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .tc       (tmr_tc)
   );

   always_comb begin
      state_n  = state;
      idx_n    = idx;
      tmr_load = 1'b0;
      tmr_val  = '0;
      case (state)
         ST_IDLE: begin
            idx_n    = '0;
            tmr_load = 1'b1;
            if (bus.enable) begin
               state_n = ST_BLANK;
               tmr_val = BLANK_LD;
            end
         end
         ST_BLANK: begin
            if (!bus.enable) begin
               state_n  = ST_IDLE;
               idx_n    = '0;
               tmr_load = 1'b1;
            end else if (tmr_tc) begin
               state_n  = ST_SHOW;
               tmr_load = 1'b1;
               tmr_val  = SHOW_LD;
            end
         end
         ST_SHOW: begin
            if (!bus.enable) begin
               state_n  = ST_IDLE;
               idx_n    = '0;
               tmr_load = 1'b1;
            end else if (tmr_tc) begin
               state_n  = ST_BLANK;
               idx_n    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
               tmr_load = 1'b1;
               tmr_val  = BLANK_LD;
            end
         end
         default: begin
            state_n  = ST_IDLE;
            idx_n    = '0;
            tmr_load = 1'b1;
         end
      endcase
   end

   // A frame begins whenever the scan enters the blank slot of digit 0.
   assign commit = (state_n == ST_BLANK) && (state != ST_BLANK) && (idx_n == '0);

   always_comb begin
      shadow_n  = shadow;
      pending_n = pending;
      pv_n      = pv;
      if (commit) begin
         if (bus.load) begin
            shadow_n = bus.digits_in;
            pv_n     = 1'b0;
         end else if (pv) begin
            shadow_n = pending;
            pv_n     = 1'b0;
         end
      end else if (bus.load) begin
         pending_n = bus.digits_in;
         pv_n      = 1'b1;
      end
   end

   always_comb begin
      code_sel = BLANK_CODE;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (idx_n == IDX_W'(k)) code_sel = shadow_n[4*k +: 4];
      end
   end

   // Outputs are computed from the next state so they line up with it.
   always_comb begin
      code_n = BLANK_CODE;
      dig_n  = '1;
      case (state_n)
         ST_BLANK: code_n = code_sel;
         ST_SHOW: begin
            code_n       = code_q;
            dig_n[idx_n] = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         idx     <= '0;
         shadow  <= '0;
         pending <= '0;
         pv      <= 1'b0;
         code_q  <= BLANK_CODE;
         dig_q   <= '1;
         fs_q    <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         shadow  <= shadow_n;
         pending <= pending_n;
         pv      <= pv_n;
         code_q  <= code_n;
         dig_q   <= dig_n;
         fs_q    <= commit;
      end
   end

   assign bus.code_out    = code_q;
   assign bus.dig_en_n    = dig_q;
   assign bus.digit_idx   = idx;
   assign bus.frame_start = fs_q;
   assign state_dbg       = state;

endmodule

// File: tb/tb_display_scan_mux.sv
// Bench for display_scan_mux: frame-position model plus directed scenarios
// with hand-computed pins, run at 4 digits / 4 show / 2 blank cycles.
module tb_display_scan_mux;
   import display_scan_mux_pkg::*;

   localparam int N      = 4;
   localparam int S      = 4;
   localparam int B      = 2;
   localparam int SLOT   = B + S;
   localparam int PERIOD = N * SLOT;

   logic        clk;
   logic        rst_n;
   scan_state_e state_dbg;
   int          n_tests;
   int          n_fail;

   display_scan_mux_if #(.NUM_DIGITS(N)) bus ();

   display_scan_mux #(
      .NUM_DIGITS   (N),
      .SHOW_CYCLES  (S),
      .BLANK_CYCLES (B)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model: position within the running scan ----------------
   logic        m_run;
   int          m_t;
   logic [15:0] m_shadow;
   logic [15:0] m_pend;
   logic        m_pv;

   function automatic int next_t(input logic run, input int t);
      return run ? t + 1 : 0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run    <= 1'b0;
         m_t      <= 0;
         m_shadow <= '0;
         m_pend   <= '0;
         m_pv     <= 1'b0;
      end else if (!bus.enable) begin
         m_run <= 1'b0;
         m_t   <= 0;
         if (bus.load) begin
            m_pend <= bus.digits_in;
            m_pv   <= 1'b1;
         end
      end else begin
         m_run <= 1'b1;
         m_t   <= next_t(m_run, m_t);
         if (next_t(m_run, m_t) % PERIOD == 0) begin
            if (bus.load) begin
               m_shadow <= bus.digits_in;
               m_pv     <= 1'b0;
            end else if (m_pv) begin
               m_shadow <= m_pend;
               m_pv     <= 1'b0;
            end
         end else if (bus.load) begin
            m_pend <= bus.digits_in;
            m_pv   <= 1'b1;
         end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      int          ph, dg, wi;
      logic [15:0] ec, ed, ei, ef, es;
      if (!m_run) begin
         ec = 16'h0; ed = 16'hF; ei = 16'h0; ef = 16'h0; es = 16'(ST_IDLE);
      end else begin
         ph = m_t % PERIOD;
         dg = ph / SLOT;
         wi = ph % SLOT;
         ec = 16'(m_shadow[dg*4 +: 4]);
         ei = 16'(dg);
         ef = (ph == 0) ? 16'h1 : 16'h0;
         ed = (wi < B) ? 16'hF : 16'(4'hF & ~(4'b0001 << dg));
         es = (wi < B) ? 16'(ST_BLANK) : 16'(ST_SHOW);
      end
      check("code_out",    16'(bus.code_out),    ec);
      check("dig_en_n",    16'(bus.dig_en_n),    ed);
      check("digit_idx",   16'(bus.digit_idx),   ei);
      check("frame_start", 16'(bus.frame_start), ef);
      check("state",       16'(state_dbg),       es);
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   task automatic load_word(input logic [15:0] w);
      bus.load      = 1'b1;
      bus.digits_in = w;
      tick();
      bus.load      = 1'b0;
   endtask

   task automatic pin_out(input string name, input logic [3:0] code,
                          input logic [3:0] dig, input logic [1:0] idx, input logic fs);
      check({name, ".code"}, 16'(bus.code_out),    16'(code));
      check({name, ".dig"},  16'(bus.dig_en_n),    16'(dig));
      check({name, ".idx"},  16'(bus.digit_idx),   16'(idx));
      check({name, ".fs"},   16'(bus.frame_start), 16'(fs));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.enable    = 1'b0;
      bus.load      = 1'b0;
      bus.digits_in = '0;
      repeat (2) @(posedge clk);
      #1;
      pin_out("reset", 4'h0, 4'b1111, 2'd0, 1'b0);
      rst_n = 1'b1;

      // basic scan of EDC1 loaded while dark
      load_word(16'hEDC1);
      bus.enable = 1'b1;
      tick();                                        // t=0
      pin_out("f0_start", 4'h1, 4'b1111, 2'd0, 1'b1);
      run(2);  pin_out("f0_d0", 4'h1, 4'b1110, 2'd0, 1'b0);
      run(6);  pin_out("f0_d1", 4'hC, 4'b1101, 2'd1, 1'b0);
      run(6);  pin_out("f0_d2", 4'hD, 4'b1011, 2'd2, 1'b0);
      run(6);  pin_out("f0_d3", 4'hE, 4'b0111, 2'd3, 1'b0);
      run(4);  pin_out("f1_start", 4'h1, 4'b1111, 2'd0, 1'b1);   // t=24

      // mid-frame load shows up only after the next frame start
      run(8);                                        // t=32, digit 1 lit
      load_word(16'h0001);                           // t=33
      run(5);  pin_out("mid_d2_old", 4'hD, 4'b1011, 2'd2, 1'b0);  // t=38
      run(6);  pin_out("mid_d3_old", 4'hE, 4'b0111, 2'd3, 1'b0);  // t=44
      run(4);  pin_out("mid_f2", 4'h1, 4'b1111, 2'd0, 1'b1);      // t=48
      run(8);  pin_out("mid_d1_new", 4'h0, 4'b1101, 2'd1, 1'b0);  // t=56

      // two loads in one frame: last one wins
      load_word(16'h1111);                           // t=57
      run(2);                                        // t=59
      load_word(16'h4444);                           // t=60
      run(12); pin_out("two_loads", 4'h4, 4'b1111, 2'd0, 1'b1);   // t=72

      // load on the commit edge bypasses a stale pending value
      run(8);                                        // t=80
      load_word(16'h5555);                           // t=81
      run(14);                                       // t=95
      load_word(16'h9876);                           // t=96
      pin_out("commit_load", 4'h6, 4'b1111, 2'd0, 1'b1);
      run(24); pin_out("commit_next", 4'h6, 4'b1111, 2'd0, 1'b1); // t=120

      // enable dropped during blank of digit 3
      run(18); pin_out("blank_d3", 4'h9, 4'b1111, 2'd3, 1'b0);    // t=138
      bus.enable = 1'b0;
      tick();  pin_out("drop_idle", 4'h0, 4'b1111, 2'd0, 1'b0);
      run(3);
      bus.enable = 1'b1;
      tick();  pin_out("reenable", 4'h6, 4'b1111, 2'd0, 1'b1);
      run(2);  pin_out("reenable_d0", 4'h6, 4'b1110, 2'd0, 1'b0);

      // load while dark is committed at restart
      run(6);
      bus.enable = 1'b0;
      load_word(16'hABCD);
      run(2);
      bus.enable = 1'b1;
      tick();  pin_out("dark_load", 4'hD, 4'b1111, 2'd0, 1'b1);

      // asynchronous reset in the middle of digit 2
      run(14); pin_out("pre_reset_d2", 4'hB, 4'b1011, 2'd2, 1'b0);
      rst_n = 1'b0;
      #1;
      pin_out("async_reset", 4'h0, 4'b1111, 2'd0, 1'b0);
      tick();
      rst_n = 1'b1;
      tick();                                        // t=0 after reset
      run(2);  pin_out("post_reset_d0", 4'h0, 4'b1110, 2'd0, 1'b0);
      run(30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/display_scan_mux.md
Name: display_scan_mux

Overview:
- Time-multiplexed driver for a common-anode N-digit 7-segment display.
- Holds one 4-bit digit code per digit and scans them in turn.
- Presents the active digit's code to the downstream BCD_7SEG decoder and drives the active-low digit enables.
- Inserts a blanking gap between digits to suppress ghosting. Updates are frame-coherent, so the display never tears.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; must be >= 2.
- SHOW_CYCLES, 50000: clk cycles each digit is lit.
- BLANK_CYCLES, 16: clk cycles with all digits off before each digit is lit; must be >= 1.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- enable  input  1  1 = scan runs; 0 = display dark.
- load  input  1  single-cycle strobe; captures digits_in.
- digits_in  input  4*NUM_DIGITS  digit codes; digit k is bits [4k+3:4k], with digit 0 rightmost.
- code_out  output  4  code presented to BCD_7SEG for the current or next digit.
- dig_en_n  output  NUM_DIGITS  active-low digit enables; at most one bit is 0.
- digit_idx  output  clog2(NUM_DIGITS)  index of the digit being blanked-for or shown.
- frame_start  output  1  one-cycle pulse when a new frame begins at digit 0.

Behaviour:
- Reset is asynchronous and active-low.
- All outputs are registered.

Reset values:
- code_out = 4'h0 (the decoder's blank code).
- dig_en_n = all 1.
- digit_idx = 0.
- frame_start = 0.
- shadow register = 0.
- pending register = 0, pending_valid = 0.
- State = IDLE, cycle counter = 0.

Registers:
- pending: written on every load; last write wins; pending_valid is set.
- shadow: the set of codes actually displayed.

States:
- IDLE:
  - dig_en_n all 1, code_out = 4'h0.
  - On enable = 1, go to BLANK with idx = 0 and counter = 0.
- BLANK:
  - dig_en_n all 1.
  - code_out = shadow[idx], driven early so the decoder settles before the digit lights.
  - Lasts exactly BLANK_CYCLES cycles, then go to SHOW with counter = 0.
- SHOW:
  - dig_en_n[idx] = 0, all other bits 1; code_out is held.
  - Lasts exactly SHOW_CYCLES cycles.
  - Then idx = (idx == NUM_DIGITS-1) ? 0 : idx+1, and go to BLANK.

Frame commit:
- Occurs on the cycle of entry into BLANK with idx = 0, including the first entry from IDLE.
- If pending_valid: shadow <= pending and pending_valid is cleared.
- frame_start pulses on that cycle whether or not new data was committed.
- If load is asserted on the commit cycle, digits_in bypasses pending and is committed directly; pending_valid ends at 0.

Timing:
- Frame period = NUM_DIGITS*(BLANK_CYCLES+SHOW_CYCLES) cycles.
- Load-to-visible latency is at most one frame plus BLANK_CYCLES.

Other rules:
- enable falling in any state: the next cycle is IDLE with outputs at IDLE values, idx = 0 and counter = 0. Pending and shadow are retained.
- enable stays 1 in IDLE: the scan restarts at digit 0.
- load while enable = 0: captured into pending; committed when the scan next starts.
- Codes are passed through unmodified. Code interpretation, including blanking with 4'h0, belongs to BCD_7SEG.
- Counters are wide enough for max(SHOW_CYCLES, BLANK_CYCLES); no wrap before the terminal count.

Decomposition:
- Shared package holds:
  - the BLANK_CODE constant (4'h0);
  - the state enum IDLE/BLANK/SHOW;
  - a clog2-based width function for the index.
- One natural sub-module, scan_timer: a loadable down-counter with a terminal-count output. It is reused for both the BLANK and SHOW intervals.

Test Plan:
All scenarios use NUM_DIGITS=4, SHOW_CYCLES=4, BLANK_CYCLES=2.
1. Reset mid-SHOW of digit 2 -> outputs immediately reset (code_out=0, dig_en_n=4'b1111); after release with enable=1, digit 0 is lit 2 cycles later.
2. load digits_in=16'hEDC1, enable=1 -> dig_en_n sequence 1110,1101,1011,0111, each lit 4 cycles with 2 cycles of 1111 between; code_out is 1,C,D,E; frame_start pulses every 24 cycles.
3. load 16'h0001 mid-frame at digit 1 -> digits 2 and 3 still show the old codes; the new codes appear only after the next frame_start.
4. Two loads in one frame (16'h1111 then 16'h4444) -> only 16'h4444 is ever displayed.
5. load on the exact commit cycle -> that data is shown in the frame starting on that cycle.
6. enable dropped during BLANK of digit 3 -> the next cycle has dig_en_n=1111 and digit_idx=0; re-enable restarts at digit 0 with a frame_start pulse.
